// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the dcache bus.
// Accepts one LOAD or STORE per cycle and acknowledges it with a 4-bit tag.
// Load data comes back tagged exactly LATENCY cycles after the accept edge.
//
// Handshake: a command is valid when proc2mem_command is LOAD or STORE.
// The responder is ready when mem2proc_response != 0 in that same cycle.
// The transfer completes at that clock edge. On a rejected command
// (response 0) nothing changes and the requester must retry.
// A returned load (mem2proc_tag != 0) is shown for one cycle only and has
// no back-pressure.
module dmem_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int XLEN            = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [3:0] MAX_OUT4  = 4'(MAX_OUTSTANDING);

    // Backing array
    logic [63:0] mem_q [MEM_WORDS];

    // Tag counter and in-flight load count
    logic [3:0] next_tag_q, next_tag_d;
    logic [3:0] inflight_q, inflight_d;

    // Return pipeline: index 0 is stage 1, index LATENCY-1 drives the outputs
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [3:0]         tag_q  [LATENCY];
    logic [3:0]         tag_d  [LATENCY];
    logic [63:0]        data_q [LATENCY];
    logic [63:0]        data_d [LATENCY];

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          retiring;
    logic [3:0]    occupancy;
    logic          load_ok;
    logic          store_ok;
    logic          accept;
    logic          unused_addr_bits;

    // The byte offset within a word plays no part in addressing
    assign unused_addr_bits = ^proc2mem_addr[2:0];

    // Accept decision, tag and occupancy next-state, pipeline shift, outputs
    always_comb begin
        word_idx  = proc2mem_addr[3 +: AW];
        in_range  = (proc2mem_addr[XLEN-1:3+AW] == '0);
        retiring  = valid_q[LATENCY-1];
        // The slot that retires this cycle frees up for a new load in the same cycle
        occupancy = inflight_q - {3'b000, retiring};

        load_ok   = (proc2mem_command == CMD_LOAD) && !reset && in_range
                    && (occupancy < MAX_OUT4);
        store_ok  = (proc2mem_command == CMD_STORE) && !reset && in_range;
        accept    = load_ok || store_ok;

        mem2proc_response = accept ? next_tag_q : 4'd0;

        next_tag_d = next_tag_q;
        if (accept) begin
            // Tag 0 means "no tag", so the counter skips it on wrap
            next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
        end

        inflight_d = inflight_q + {3'b000, load_ok} - {3'b000, retiring};

        valid_d[0] = load_ok;
        tag_d[0]   = next_tag_q;
        data_d[0]  = mem_q[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
            data_d[i]  = data_q[i-1];
        end

        mem2proc_tag  = retiring ? tag_q[LATENCY-1]  : 4'd0;
        mem2proc_data = retiring ? data_q[LATENCY-1] : 64'd0;
    end

    // Tag counter, occupancy and return pipeline registers
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag_q <= 4'd1;
            inflight_q <= 4'd0;
            valid_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= 4'd0;
                data_q[i] <= 64'd0;
            end
        end else begin
            next_tag_q <= next_tag_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Backing array: cleared on reset, written by accepted stores
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (store_ok) begin
            mem_q[word_idx] <= proc2mem_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY 4, MAX_OUTSTANDING 2).
// Expected load returns are queued at accept time and checked when due.
module tb_dmem_responder;

    localparam int         MEM_WORDS = 1024;
    localparam int         LATENCY   = 4;
    localparam int         MAX_OUT   = 2;
    localparam int         XLEN      = 32;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [1:0] CMD_RSVD  = 2'd3;

    logic            clock;
    logic            reset;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    // Each entry: {due cycle[31:0], tag[3:0], data[63:0]}
    logic [99:0] exp_q[$];
    logic [63:0] mem_model [int];
    int          cyc;
    int          n_checks;
    int          n_fail;

    dmem_responder #(
        .MEM_WORDS       (MEM_WORDS),
        .LATENCY         (LATENCY),
        .MAX_OUTSTANDING (MAX_OUT),
        .XLEN            (XLEN)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    // Drive one cycle, check response and any due return, update the model
    task automatic step(input logic rst, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [3:0] exp_resp);
        logic [99:0] e;
        logic [63:0] mdata;
        int          w;
        reset            = rst;
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = wdata;
        @(negedge clock);
        chk("response", {60'd0, mem2proc_response}, {60'd0, exp_resp});
        if (exp_q.size() > 0 && int'(exp_q[0][99:68]) == cyc) begin
            e = exp_q.pop_front();
            chk("ret_tag", {60'd0, mem2proc_tag}, {60'd0, e[67:64]});
            chk("ret_data", mem2proc_data, e[63:0]);
        end else begin
            chk("idle_tag", {60'd0, mem2proc_tag}, 64'd0);
            chk("idle_data", mem2proc_data, 64'd0);
        end
        w = int'(addr[12:3]);
        if (exp_resp != 4'd0) begin
            if (cmd == CMD_STORE) begin
                mem_model[w] = wdata;
            end else begin
                mdata = mem_model.exists(w) ? mem_model[w] : 64'd0;
                exp_q.push_back({32'(cyc + LATENCY), exp_resp, mdata});
            end
        end
        if (rst) begin
            exp_q.delete();
            mem_model.delete();
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, CMD_NONE, 32'h0, 64'h0, 4'd0);
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        reset            = 1'b1;
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        #1;

        // Reset: response forced to 0 even with a load presented
        step(1'b1, CMD_LOAD, 32'h10, 64'h0, 4'd0);
        step(1'b1, CMD_LOAD, 32'h10, 64'h0, 4'd0);

        // Store then load, read-after-write on the next cycle
        step(1'b0, CMD_STORE, 32'h10, 64'hFFFF_1234_4321_FFFF, 4'd1);
        step(1'b0, CMD_LOAD,  32'h10, 64'h0, 4'd2);
        idle(5);

        // Aligned aliasing: byte offset ignored
        step(1'b0, CMD_STORE, 32'h810, 64'hABCD_0110_1001_ABCD, 4'd3);
        step(1'b0, CMD_LOAD,  32'h817, 64'h0, 4'd4);
        idle(5);

        // Backpressure with two outstanding; retiring slot frees in its cycle
        step(1'b0, CMD_LOAD, 32'h10, 64'h0, 4'd5);
        step(1'b0, CMD_LOAD, 32'h10, 64'h0, 4'd6);
        step(1'b0, CMD_LOAD, 32'h10, 64'h0, 4'd0);
        step(1'b0, CMD_LOAD, 32'h10, 64'h0, 4'd0);
        step(1'b0, CMD_LOAD, 32'h810, 64'h0, 4'd7);
        step(1'b0, CMD_LOAD, 32'h10, 64'h0, 4'd8);
        idle(5);

        // Out of range and reserved command; last word is still in range
        step(1'b0, CMD_LOAD,  32'h2000, 64'h0, 4'd0);
        step(1'b0, CMD_STORE, 32'h2008, 64'h1111, 4'd0);
        step(1'b0, CMD_RSVD,  32'h10, 64'h0, 4'd0);
        step(1'b0, CMD_STORE, 32'h1FF8, 64'h0123_4567_89AB_CDEF, 4'd9);
        step(1'b0, CMD_LOAD,  32'h1FF8, 64'h0, 4'd10);
        idle(5);

        // Reset mid-flight: queued loads are dropped, tags restart at 1
        step(1'b0, CMD_LOAD, 32'h10, 64'h0, 4'd11);
        step(1'b0, CMD_LOAD, 32'h1FF8, 64'h0, 4'd12);
        step(1'b1, CMD_LOAD, 32'h10, 64'h0, 4'd0);
        idle(6);

        // Tag wrap: 16 stores get 1..15 then 1
        for (int i = 0; i < 16; i++) begin
            step(1'b0, CMD_STORE, 32'(i * 8), {$urandom, $urandom}, 4'((i % 15) + 1));
        end

        // Array cleared by reset; freshly stored word reads back
        step(1'b0, CMD_LOAD, 32'h810, 64'h0, 4'd2);
        step(1'b0, CMD_LOAD, 32'h18,  64'h0, 4'd3);
        idle(6);

        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Synthesizable data-memory responder on the memory side of the cache-to-memory bus: it accepts one load or store per cycle from the data cache, acknowledges it with a 4-bit transaction tag, and returns load data tagged after a fixed latency. It sits between `dcache` (`proc2Dmem_*` / `Dmem2proc_*`) and a word-addressed 64-bit backing array. It replaces the behavioural memory model in cache benches and in the full pipeline.

## Interface

Parameters:
- `MEM_WORDS`, default 1024: number of 64-bit words in the backing array; must be a power of two.
- `LATENCY`, default 4: cycles from the accept edge to the tag return; legal range 1..14.
- `MAX_OUTSTANDING`, default 4: maximum loads in flight; legal range 1..`LATENCY`.

Ports (clock and reset first):
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `proc2mem_command` in 2: 0 = NONE, 1 = LOAD, 2 = STORE, 3 = treated as NONE.
- `proc2mem_addr` in `XLEN`: byte address; `addr[2:0]` is ignored; word index is `addr[3 +: log2(MEM_WORDS)]`.
- `proc2mem_data` in 64: store data (full 64-bit word).
- `mem2proc_response` out 4: tag of the accepted command; 0 = rejected or no command. Combinational, same cycle as the command.
- `mem2proc_data` out 64: load data, valid only while `mem2proc_tag != 0`; 0 otherwise.
- `mem2proc_tag` out 4: tag of the load being returned this cycle; 0 = none.

## Operation

- **Tag counter** `next_tag`: 4-bit, resets to 1, counts 1..15 and wraps 15 -> 1 (0 is never issued). It advances by one on every accepted LOAD or STORE.
- **Acceptance:** a command is accepted when all of the following hold:
  - command is LOAD or STORE,
  - `reset` = 0,
  - the address is in range (`addr < MEM_WORDS*8`),
  - for LOAD only: `inflight - retiring_now < MAX_OUTSTANDING`. `retiring_now` is 1 if a tag is being returned this cycle.
- **Accepted command:** `mem2proc_response = next_tag`.
- **Rejected command:** `mem2proc_response = 0`, no state changes, and the requester retries.
- **Store accept:** the array word is written at the accept edge. No tag is returned later.
- **Load accept:** the array word is read at the accept edge (snapshot). `{tag, data}` enters stage 1 of a `LATENCY`-deep valid/tag/data shift pipeline and `inflight` increments.
- **Stage `LATENCY`:** while valid, drives `mem2proc_tag` and `mem2proc_data` for exactly one cycle. `inflight` decrements at the end of that cycle.
- **Simultaneous accept and retire:** `inflight` is unchanged.
- **Tag uniqueness:** in-flight tags are always unique, because at most 14 are live and there are 15 tag values.
- **Read-after-write:** a store followed by a load to the same word on the next cycle returns the new data. Within a single cycle, ordering is impossible because there is one command port.
- **Reset:**
  - array cleared to 0,
  - pipeline valids cleared,
  - `inflight` = 0, `next_tag` = 1.
  - In-flight loads are dropped and their tags are never returned.

## Timing

- **Reset values:** `mem2proc_response` = 0 (forced while `reset` is high), `mem2proc_tag` = 0, `mem2proc_data` = 0.
- **Response:** combinational in the command cycle (cycle C). The requester samples it at the C edge.
- **Load return:** the tag appears in cycle C+`LATENCY` and is held for one cycle only. The requester must catch it then; there is no retry.
- **Throughput:** one command per cycle.
  - Back-to-back loads return on consecutive cycles in issue order.
  - With `MAX_OUTSTANDING = LATENCY`, a continuous load stream is never rejected.
- **Wrap:** the 15th accepted command gets tag 15 and the 16th gets tag 1.
- **Reset mid-operation:** no tag appears on any cycle after the reset edge until a new load completes its full `LATENCY`.

## Test plan

- **Store then load, defaults:** STORE addr 0x10 data 0xFFFF_1234_4321_FFFF in cycle 1, then LOAD 0x10 in cycle 2. Required: responses 1 and 2; tag 2 with that data in cycle 6; no tag 1 is ever returned.
- **Aligned aliasing:** STORE 0x810 data 0xABCD_0110_1001_ABCD, then LOAD 0x817. Required: same word returned; `addr[2:0]` is ignored.
- **Backpressure:** `MAX_OUTSTANDING` = 2, `LATENCY` = 4, LOADs in 4 consecutive cycles. Required responses 1, 2, 0, 0. A retried load in the cycle tag 1 returns is accepted as tag 3, because the retiring slot frees.
- **Tag wrap:** 16 consecutive STOREs. Required responses 1..15, then 1; `mem2proc_tag` stays 0 throughout.
- **Out of range and reserved command:** LOAD at `MEM_WORDS*8` -> response 0, tag counter unchanged. Command 3 -> response 0.
- **Reset mid-flight:** two LOADs accepted, reset asserted one cycle later. Required: all outputs 0, no tag ever returned for those loads, and the next accepted command gets tag 1.
